// File: rtl/iob_eth_tx_bd_sched.sv
// TX buffer-descriptor scheduler: walks the TX BD ring, fetches ready
// descriptors, hands one frame at a time to the TX DMA, then writes the
// descriptor status back and raises the per-frame interrupts.
module iob_eth_tx_bd_sched #(
   parameter int BD_NUM_LOG2 = 7,
   parameter int PTR_W       = 32,
   parameter int POLL_GAP    = 16
) (
   input  logic                   clk_i,
   input  logic                   arst_n_i,
   input  logic                   cke_i,
   input  logic                   tx_en_i,
   input  logic [BD_NUM_LOG2-1:0] tx_bd_num_i,
   output logic                   bd_en_o,
   output logic                   bd_we_o,
   output logic [BD_NUM_LOG2:0]   bd_addr_o,
   output logic [31:0]            bd_wdata_o,
   input  logic [31:0]            bd_rdata_i,
   output logic                   dma_valid_o,
   input  logic                   dma_ready_i,
   output logic [PTR_W-1:0]       dma_ptr_o,
   output logic [15:0]            dma_len_o,
   output logic                   dma_crc_o,
   output logic                   dma_pad_o,
   input  logic                   dma_done_i,
   input  logic                   dma_err_i,
   output logic                   irq_txb_o,
   output logic                   irq_txe_o,
   output logic [BD_NUM_LOG2-1:0] cur_bd_o,
   output logic                   busy_o
);

   // BD control word bit positions
   localparam int RD_BIT  = 15;
   localparam int IRQ_BIT = 14;
   localparam int WR_BIT  = 13;
   localparam int PAD_BIT = 12;
   localparam int CRC_BIT = 11;
   localparam int UR_BIT  = 8;

   localparam int CNT_W = $clog2(POLL_GAP + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_RD_CTRL,
      S_WAIT_CTRL,
      S_RD_PTR,
      S_WAIT_PTR,
      S_REQ,
      S_BUSY,
      S_WB,
      S_NEXT
   } state_t;

   state_t                 state_reg;
   logic [31:0]            ctrl_reg;
   logic [CNT_W-1:0]       poll_reg;
   logic [BD_NUM_LOG2:0]   cur_inc;
   logic                   wrap;

   // Status word written back: ready cleared, underrun reflects the error.
   function automatic logic [31:0] wb_word(input logic [31:0] ctrl, input logic err);
      logic [31:0] w;
      w          = ctrl;
      w[RD_BIT]  = 1'b0;
      w[UR_BIT]  = err;
      return w;
   endfunction

   // Ring advance: explicit wrap bit, last entry, or an index beyond a shrunk ring.
   assign cur_inc = {1'b0, cur_bd_o} + (BD_NUM_LOG2+1)'(1);
   assign wrap    = ctrl_reg[WR_BIT] || (cur_inc >= {1'b0, tx_bd_num_i});
   assign busy_o  = (state_reg != S_IDLE);

   // Scheduler FSM with registered outputs; interrupts are single-cycle pulses
   // that clear even while the clock enable is low so they never repeat.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_reg   <= S_IDLE;
         ctrl_reg    <= '0;
         poll_reg    <= '0;
         cur_bd_o    <= '0;
         bd_en_o     <= 1'b0;
         bd_we_o     <= 1'b0;
         bd_addr_o   <= '0;
         bd_wdata_o  <= '0;
         dma_valid_o <= 1'b0;
         dma_ptr_o   <= '0;
         dma_len_o   <= '0;
         dma_crc_o   <= 1'b0;
         dma_pad_o   <= 1'b0;
         irq_txb_o   <= 1'b0;
         irq_txe_o   <= 1'b0;
      end else begin
         irq_txb_o <= 1'b0;
         irq_txe_o <= 1'b0;
         if (cke_i) begin
            case (state_reg)
               S_IDLE: begin
                  if (poll_reg != '0) begin
                     poll_reg <= poll_reg - CNT_W'(1);
                  end else if (tx_en_i && (tx_bd_num_i != '0)) begin
                     state_reg <= S_RD_CTRL;
                     bd_en_o   <= 1'b1;
                     bd_we_o   <= 1'b0;
                     bd_addr_o <= {cur_bd_o, 1'b0};
                  end
               end
               S_RD_CTRL: begin
                  bd_en_o   <= 1'b0;
                  state_reg <= S_WAIT_CTRL;
               end
               S_WAIT_CTRL: begin
                  ctrl_reg <= bd_rdata_i;
                  if (!bd_rdata_i[RD_BIT]) begin
                     poll_reg  <= CNT_W'(POLL_GAP);
                     state_reg <= S_IDLE;
                  end else begin
                     bd_en_o   <= 1'b1;
                     bd_addr_o <= {cur_bd_o, 1'b1};
                     state_reg <= S_RD_PTR;
                  end
               end
               S_RD_PTR: begin
                  bd_en_o   <= 1'b0;
                  state_reg <= S_WAIT_PTR;
               end
               S_WAIT_PTR: begin
                  dma_ptr_o <= PTR_W'(bd_rdata_i);
                  if (ctrl_reg[31:16] == 16'd0) begin
                     // Zero-length frame: skip DMA and report it as an error.
                     bd_en_o    <= 1'b1;
                     bd_we_o    <= 1'b1;
                     bd_addr_o  <= {cur_bd_o, 1'b0};
                     bd_wdata_o <= wb_word(ctrl_reg, 1'b1);
                     irq_txe_o  <= 1'b1;
                     state_reg  <= S_WB;
                  end else begin
                     dma_valid_o <= 1'b1;
                     dma_len_o   <= ctrl_reg[31:16];
                     dma_crc_o   <= ctrl_reg[CRC_BIT];
                     dma_pad_o   <= ctrl_reg[PAD_BIT];
                     state_reg   <= S_REQ;
                  end
               end
               S_REQ: begin
                  if (dma_ready_i) begin
                     dma_valid_o <= 1'b0;
                     state_reg   <= S_BUSY;
                  end
               end
               S_BUSY: begin
                  if (dma_done_i) begin
                     bd_en_o    <= 1'b1;
                     bd_we_o    <= 1'b1;
                     bd_addr_o  <= {cur_bd_o, 1'b0};
                     bd_wdata_o <= wb_word(ctrl_reg, dma_err_i);
                     irq_txe_o  <= dma_err_i;
                     irq_txb_o  <= !dma_err_i && ctrl_reg[IRQ_BIT];
                     state_reg  <= S_WB;
                  end
               end
               S_WB: begin
                  bd_en_o   <= 1'b0;
                  bd_we_o   <= 1'b0;
                  state_reg <= S_NEXT;
               end
               S_NEXT: begin
                  cur_bd_o  <= wrap ? '0 : cur_inc[BD_NUM_LOG2-1:0];
                  poll_reg  <= '0;
                  state_reg <= S_IDLE;
               end
               default: begin
                  state_reg <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_iob_eth_tx_bd_sched.sv
// Directed bench for the TX BD scheduler: BD RAM and DMA responders plus a
// transaction-level ring model checked every cycle.
module tb_iob_eth_tx_bd_sched;

   localparam int BN = 7;
   localparam int PW = 32;
   localparam int PG = 16;

   logic          clk_i = 1'b0;
   logic          arst_n_i;
   logic          cke_i;
   logic          tx_en_i;
   logic [BN-1:0] tx_bd_num_i;
   logic          bd_en_o, bd_we_o;
   logic [BN:0]   bd_addr_o;
   logic [31:0]   bd_wdata_o;
   logic [31:0]   bd_rdata_i;
   logic          dma_valid_o, dma_ready_i;
   logic [PW-1:0] dma_ptr_o;
   logic [15:0]   dma_len_o;
   logic          dma_crc_o, dma_pad_o, dma_done_i, dma_err_i;
   logic          irq_txb_o, irq_txe_o;
   logic [BN-1:0] cur_bd_o;
   logic          busy_o;

   always #5 clk_i = ~clk_i;

   iob_eth_tx_bd_sched #(.BD_NUM_LOG2(BN), .PTR_W(PW), .POLL_GAP(PG)) dut (
      .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .tx_en_i(tx_en_i),
      .tx_bd_num_i(tx_bd_num_i), .bd_en_o(bd_en_o), .bd_we_o(bd_we_o),
      .bd_addr_o(bd_addr_o), .bd_wdata_o(bd_wdata_o), .bd_rdata_i(bd_rdata_i),
      .dma_valid_o(dma_valid_o), .dma_ready_i(dma_ready_i), .dma_ptr_o(dma_ptr_o),
      .dma_len_o(dma_len_o), .dma_crc_o(dma_crc_o), .dma_pad_o(dma_pad_o),
      .dma_done_i(dma_done_i), .dma_err_i(dma_err_i), .irq_txb_o(irq_txb_o),
      .irq_txe_o(irq_txe_o), .cur_bd_o(cur_bd_o), .busy_o(busy_o)
   );

   logic [31:0] mem [0:255];
   int n_cmp = 0, n_err = 0;
   int model_bd = 0, cyc = 0;
   int wb_count = 0, irqb_count = 0, irqe_count = 0, hs_count = 0, rd_count = 0;
   int last_err = 0, err_cfg = 0, ready_delay = 0, done_delay = 4;
   int rd0_q[$];
   logic [31:0] ptr_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Ring model: which BD must be touched, what the DMA must see, what gets written back.
   initial begin
      logic [31:0] orig, exp_w;
      int e, nxt;
      forever begin
         @(negedge clk_i);
         cyc++;
         if (!arst_n_i) begin
            model_bd = 0;
            continue;
         end
         if (bd_en_o && !bd_we_o) begin
            rd_count++;
            chk("rd_bd", 64'(bd_addr_o[BN:1]), 64'(model_bd));
            chk("cur_bd", 64'(cur_bd_o), 64'(model_bd));
            if (bd_addr_o == 0) rd0_q.push_back(cyc);
         end
         if (dma_valid_o) begin
            orig = mem[2*model_bd];
            chk("dma_len_nonzero", 64'(orig[31:16] != 0), 64'd1);
            chk("dma_ptr", 64'(dma_ptr_o), 64'(mem[2*model_bd+1]));
            chk("dma_len", 64'(dma_len_o), 64'(orig[31:16]));
            chk("dma_crc", 64'(dma_crc_o), 64'(orig[11]));
            chk("dma_pad", 64'(dma_pad_o), 64'(orig[12]));
         end
         if (bd_en_o && bd_we_o) begin
            orig = mem[2*model_bd];
            e = (orig[31:16] == 0) ? 1 : last_err;
            exp_w = orig;
            exp_w[15] = 1'b0;
            exp_w[8] = e[0];
            chk("wb_addr", 64'(bd_addr_o), 64'(2*model_bd));
            chk("wb_data", 64'(bd_wdata_o), 64'(exp_w));
            chk("irq_txe", 64'(irq_txe_o), 64'(e[0]));
            chk("irq_txb", 64'(irq_txb_o), 64'(!e[0] && orig[14]));
            $display("wb bd=%0d data=%08h txb=%0d txe=%0d", model_bd, bd_wdata_o, irq_txb_o, irq_txe_o);
            wb_count++;
            if (irq_txb_o) irqb_count++;
            if (irq_txe_o) irqe_count++;
            nxt = model_bd + 1;
            model_bd = (orig[13] || nxt >= int'(tx_bd_num_i)) ? 0 : nxt;
         end else begin
            chk("irq_quiet", 64'({irq_txb_o, irq_txe_o}), 64'd0);
         end
      end
   end

   // BD RAM: registered read, data appears one cycle after the strobe.
   initial begin
      logic s_rd, s_wr;
      logic [BN:0] s_a;
      logic [31:0] s_d;
      bd_rdata_i = '0;
      forever begin
         @(negedge clk_i);
         s_rd = bd_en_o && !bd_we_o;
         s_wr = bd_en_o && bd_we_o;
         s_a  = bd_addr_o;
         s_d  = bd_wdata_o;
         @(posedge clk_i);
         #1;
         if (s_rd) bd_rdata_i = mem[s_a];
         if (s_wr) mem[s_a] = s_d;
      end
   end

   // DMA responder: accept after ready_delay cycles, finish done_delay later.
   initial begin
      logic aborted;
      logic [31:0] p;
      dma_ready_i = 1'b0;
      dma_done_i  = 1'b0;
      dma_err_i   = 1'b0;
      forever begin
         @(negedge clk_i);
         if (dma_valid_o && arst_n_i) begin
            p = dma_ptr_o;
            for (int i = 0; i < ready_delay; i++) @(negedge clk_i);
            dma_ready_i = 1'b1;
            @(negedge clk_i);
            dma_ready_i = 1'b0;
            hs_count++;
            ptr_q.push_back(p);
            $display("dma req ptr=%08h", p);
            aborted = 1'b0;
            for (int i = 0; i < done_delay; i++) begin
               @(negedge clk_i);
               if (!arst_n_i) aborted = 1'b1;
            end
            if (!aborted) begin
               last_err   = err_cfg;
               dma_done_i = 1'b1;
               dma_err_i  = err_cfg[0];
               @(negedge clk_i);
               dma_done_i = 1'b0;
               dma_err_i  = 1'b0;
            end
         end
      end
   end

   task automatic wait_wb(input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk_i);
         #1;
         if (wb_count >= target) break;
      end
      chk("wait_wb", 64'(wb_count >= target), 64'd1);
   endtask

   task automatic wait_hs(input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk_i);
         #1;
         if (hs_count >= target) break;
      end
      chk("wait_hs", 64'(hs_count >= target), 64'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, 64'({bd_en_o, bd_we_o, dma_valid_o, dma_crc_o, dma_pad_o,
                               irq_txb_o, irq_txe_o, busy_o, bd_addr_o, cur_bd_o}), 64'd0);
      chk({tag, "_data"}, {bd_wdata_o, dma_ptr_o}, 64'd0);
      chk({tag, "_len"}, 64'(dma_len_o), 64'd0);
   endtask

   initial begin
      int lat, hs0, r0, wb0;
      arst_n_i = 1'b0;
      cke_i = 1'b1;
      tx_en_i = 1'b0;
      tx_bd_num_i = BN'(1);
      for (int i = 0; i < 256; i++) mem[i] = '0;
      repeat (3) @(negedge clk_i);
      chk_all_zero("reset");
      arst_n_i = 1'b1;

      // single BD with wrap: latency, request fields, write-back, irq
      mem[0] = 32'h0050_E800;
      mem[1] = 32'h0000_0000;
      @(negedge clk_i);
      tx_en_i = 1'b1;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk_i);
         if (dma_valid_o) begin
            lat = i;
            break;
         end
      end
      chk("latency", 64'(lat), 64'd5);
      chk("t1_ptr", 64'(dma_ptr_o), 64'h0);
      chk("t1_len", 64'(dma_len_o), 64'd80);
      chk("t1_crc_pad", 64'({dma_crc_o, dma_pad_o}), 64'b10);
      wait_wb(1, 100);
      tx_en_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("t1_bd0", 64'(mem[0]), 64'h0050_6800);
      chk("t1_irqb", 64'(irqb_count), 64'd1);
      chk("t1_cur", 64'(cur_bd_o), 64'd0);
      repeat (25) @(posedge clk_i);

      // three-entry ring without wrap bits, then polling a not-ready BD0
      tx_bd_num_i = BN'(3);
      mem[0] = 32'h0040_8800; mem[1] = 32'h100;
      mem[2] = 32'h0040_8800; mem[3] = 32'h200;
      mem[4] = 32'h0040_8800; mem[5] = 32'h300;
      ptr_q.delete();
      tx_en_i = 1'b1;
      wait_wb(4, 300);
      repeat (3) @(posedge clk_i);
      #1;
      rd0_q.delete();
      chk("t2_nreq", 64'(ptr_q.size()), 64'd3);
      if (ptr_q.size() == 3) begin
         chk("t2_req0", 64'(ptr_q[0]), 64'h100);
         chk("t2_req1", 64'(ptr_q[1]), 64'h200);
         chk("t2_req2", 64'(ptr_q[2]), 64'h300);
      end
      chk("t2_cur", 64'(cur_bd_o), 64'd0);
      chk("t2_bd2", 64'(mem[4]), 64'h0040_0800);
      repeat (60) @(posedge clk_i);
      chk("t2_poll_reads", 64'(rd0_q.size() >= 2), 64'd1);
      if (rd0_q.size() >= 2)
         chk("t2_poll_gap", 64'(rd0_q[rd0_q.size()-1] - rd0_q[rd0_q.size()-2]), 64'(PG + 3));
      tx_en_i = 1'b0;
      repeat (25) @(posedge clk_i);

      // DMA underrun on a BD without IRQ
      mem[0] = 32'h0064_8000; mem[1] = 32'h400;
      err_cfg = 1;
      tx_en_i = 1'b1;
      wait_wb(5, 200);
      tx_en_i = 1'b0;
      err_cfg = 0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("t3_bd0", 64'(mem[0]), 64'h0064_0100);
      chk("t3_irqe", 64'(irqe_count), 64'd1);
      chk("t3_irqb", 64'(irqb_count), 64'd1);
      repeat (25) @(posedge clk_i);

      // zero-length BD at index 1: no DMA, error reported
      mem[2] = 32'h0000_C000; mem[3] = 32'h700;
      hs0 = hs_count;
      tx_en_i = 1'b1;
      wait_wb(6, 200);
      tx_en_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("t4_bd1", 64'(mem[2]), 64'h0000_4100);
      chk("t4_no_dma", 64'(hs_count), 64'(hs0));
      chk("t4_irqe", 64'(irqe_count), 64'd2);
      repeat (25) @(posedge clk_i);

      // slow ready, tx_en dropped during the transfer
      mem[4] = 32'h003C_9000; mem[5] = 32'h500;
      ready_delay = 10;
      done_delay = 20;
      tx_en_i = 1'b1;
      wait_hs(hs0 + 1, 200);
      repeat (3) @(posedge clk_i);
      tx_en_i = 1'b0;
      wait_wb(7, 200);
      r0 = rd_count;
      repeat (50) @(posedge clk_i);
      #1;
      chk("t5_no_reads", 64'(rd_count), 64'(r0));
      chk("t5_bd2", 64'(mem[4]), 64'h003C_1000);
      chk("t5_ptr", 64'(ptr_q[ptr_q.size()-1]), 64'h500);
      chk("t5_cur", 64'(cur_bd_o), 64'd0);
      ready_delay = 0;

      // asynchronous reset while the frame is in flight
      mem[0] = 32'h0050_E800; mem[1] = 32'h600;
      done_delay = 30;
      tx_en_i = 1'b1;
      wait_hs(hs0 + 2, 200);
      repeat (3) @(posedge clk_i);
      #2;
      wb0 = wb_count;
      arst_n_i = 1'b0;
      #1;
      chk_all_zero("t6_rst");
      repeat (40) @(posedge clk_i);
      #1;
      chk("t6_no_wb", 64'(wb_count), 64'(wb0));
      chk("t6_bd0_kept", 64'(mem[0]), 64'h0050_E800);
      @(negedge clk_i);
      done_delay = 4;
      arst_n_i = 1'b1;
      wait_wb(wb0 + 1, 200);
      tx_en_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("t6_bd0", 64'(mem[0]), 64'h0050_6800);
      chk("t6_ptr", 64'(ptr_q[ptr_q.size()-1]), 64'h600);
      chk("t6_cur", 64'(cur_bd_o), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
